// File: rtl/muxn_rr_stage.sv
// muxn_rr_stage: N-way valid/ready word multiplexer with a single registered
// output stage. The channel is chosen either by round-robin arbitration
// (mode=0) or by an externally driven index (mode=1).
//
// Handshake semantics (all channels and the output port): a word moves on a
// rising edge exactly when valid and ready are both high in the cycle before
// that edge. A producer holds valid and data stable until its word is taken.
// in_ready is a combinational function of mode, sel, rr_ptr, in_valid,
// out_valid and out_ready. It never depends on in_data.
module muxn_rr_stage #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic [SEL_W-1:0]            sel,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  output logic [NUM_INPUTS-1:0]       in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_sel,
  input  logic                        out_ready
);

  // rr_ptr holds the last channel served in round-robin mode. The scan starts
  // one past it, so the last winner drops to lowest priority. Its reset value
  // is NUM_INPUTS-1, which gives channel 0 first priority out of reset.
  localparam logic [SEL_W-1:0] RR_RESET = SEL_W'(NUM_INPUTS - 1);

  logic [SEL_W-1:0]      rr_ptr;
  logic                  load_en;
  logic [NUM_INPUTS-1:0] grant;
  logic [SEL_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [WIDTH-1:0]      grant_word;
  logic                  fire;

  // The output register can take a new word when it is empty or when its
  // current word is leaving in this same cycle. This gives full throughput.
  assign load_en = !out_valid || out_ready;

  // Grant selection. There is at most one grant bit, and only on a valid
  // channel. In fixed mode an out-of-range sel matches no channel, so nothing
  // is granted. In round-robin mode the outer loop walks priority order
  // (rr_ptr+1 .. rr_ptr, wrapping). The inner loop matches that position to a
  // channel with a constant index.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (mode) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant[i]  = 1'b1;
          grant_idx = SEL_W'(i);
          grant_any = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NUM_INPUTS; k++) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (!grant_any && in_valid[i] &&
              i == ((int'(rr_ptr) + k) % NUM_INPUTS)) begin
            grant[i]  = 1'b1;
            grant_idx = SEL_W'(i);
            grant_any = 1'b1;
          end
        end
      end
    end
  end

  // Data path mux driven by the one-hot grant vector.
  always_comb begin
    grant_word = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) grant_word = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Ready goes only to the granted channel, and only when the output stage
  // can load. It is forced low while reset is held.
  always_comb begin
    in_ready = '0;
    if (!reset && load_en) in_ready = grant;
  end

  // A transfer happens whenever some channel is granted and the stage can
  // load. Grant already implies in_valid for that channel.
  assign fire = grant_any && load_en && !reset;

  // Output register. On a transfer it loads the word and its source index.
  // On a pop with no new word it empties, but keeps the old data and sel
  // values. On a stall it holds everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= grant_word;
      out_sel   <= grant_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer update. It advances only on round-robin transfers, so
  // a fixed-select period leaves the rotation where it was.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= RR_RESET;
    end else if (fire && !mode) begin
      rr_ptr <= grant_idx;
    end
  end

endmodule

// File: tb/tb_muxn_rr_stage.sv
// Bench for muxn_rr_stage (WIDTH=32, NUM_INPUTS=4). Stimulus is driven 1 ns
// after each rising edge. Checks are made on the falling edge. Expected output
// words are queued when a transfer is expected and compared when the DUT pops
// them.
module tb_muxn_rr_stage;

  localparam int W = 32;
  localparam int N = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
  } exp_t;

  typedef struct {
    logic          mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  valid;
    logic [N-1:0]  exp_ready;
  } vec_t;

  logic            clk;
  logic            reset;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_ready;

  logic [W-1:0]    chan_data [N];
  exp_t            exp_q [$];
  int              pass_cnt;
  int              total_cnt;
  vec_t            vecs [10];

  muxn_rr_stage #(.WIDTH(W), .NUM_INPUTS(N), .SEL_W(SW)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .sel      (sel),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*W +: W] = chan_data[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '1;
    out_ready = 1'b0;
    reset     = 1'b1;
    #1;
    check("ready_in_reset", 64'(in_ready), 64'h0);
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_sel", 64'(out_sel), 64'h0);
    reset    = 1'b0;
    in_valid = '0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // Check in_ready on the falling edge against the expected grant. If a
  // transfer is expected, queue the word. Then advance past the next rising edge.
  task automatic expect_cycle(input string name, input logic [N-1:0] exp_ready);
    exp_t e;
    @(negedge clk);
    check(name, 64'(in_ready), 64'(exp_ready));
    for (int i = 0; i < N; i++) begin
      if (exp_ready[i]) begin
        e.sel  = SW'(i);
        e.data = chan_data[i];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_pop: sel %0d data %0h with empty queue", out_sel, out_data);
      end else begin
        e = exp_q.pop_front();
        check("pop_sel", 64'(out_sel), 64'(e.sel));
        check("pop_data", 64'(out_data), 64'(e.data));
      end
    end
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    for (int i = 0; i < N; i++) chan_data[i] = 32'hA0 + 32'(i);

    // Single-cycle grant table, each row applied from a fresh reset (rr_ptr=3).
    vecs[0] = '{1'b0, 2'd0, 4'b1111, 4'b0001};
    vecs[1] = '{1'b0, 2'd0, 4'b0100, 4'b0100};
    vecs[2] = '{1'b0, 2'd0, 4'b1000, 4'b1000};
    vecs[3] = '{1'b0, 2'd0, 4'b0000, 4'b0000};
    vecs[4] = '{1'b0, 2'd0, 4'b0110, 4'b0010};
    vecs[5] = '{1'b1, 2'd2, 4'b1111, 4'b0100};
    vecs[6] = '{1'b1, 2'd2, 4'b1011, 4'b0000};
    vecs[7] = '{1'b1, 2'd0, 4'b0001, 4'b0001};
    vecs[8] = '{1'b1, 2'd3, 4'b0111, 4'b0000};
    vecs[9] = '{1'b1, 2'd1, 4'b1110, 4'b0010};

    for (int v = 0; v < 10; v++) begin
      do_reset();
      for (int i = 0; i < N; i++) chan_data[i] = $urandom_range(32'hFFFF, 0) ^ (32'h1 << (16 + i));
      mode      = vecs[v].mode;
      sel       = vecs[v].sel;
      in_valid  = vecs[v].valid;
      out_ready = 1'b1;
      expect_cycle($sformatf("vec%0d_ready", v), vecs[v].exp_ready);
      in_valid = '0;
      expect_cycle("vec_idle", 4'b0000);
      expect_cycle("vec_idle", 4'b0000);
    end

    // Round-robin fairness: all valid, continuous consumer.
    do_reset();
    for (int i = 0; i < N; i++) chan_data[i] = 32'hA0 + 32'(i);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      expect_cycle("rr_ready", 4'b0001 << (k % 4));
      check("rr_out_valid", 64'(out_valid), 64'h1);
    end
    in_valid = '0;
    expect_cycle("rr_drain", 4'b0000);
    expect_cycle("rr_drain", 4'b0000);
    check("rr_empty", 64'(out_valid), 64'h0);

    // Sparse requests with wrap: move rr_ptr to 2, then request only 0 and 1.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 4'b0100;
    expect_cycle("sp_set", 4'b0100);
    in_valid = 4'b0011;
    expect_cycle("sp_g0", 4'b0001);
    expect_cycle("sp_g1", 4'b0010);
    expect_cycle("sp_g0b", 4'b0001);
    in_valid = '0;
    expect_cycle("sp_drain", 4'b0000);
    expect_cycle("sp_drain", 4'b0000);

    // Backpressure: hold DEADBEEF for 3 stalled cycles, then pop and reload.
    do_reset();
    chan_data[0] = 32'hDEADBEEF;
    chan_data[1] = 32'h11111111;
    out_ready = 1'b1;
    in_valid  = 4'b0001;
    expect_cycle("bp_load", 4'b0001);
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_cycle("bp_stall_ready", 4'b0000);
      check("bp_hold_valid", 64'(out_valid), 64'h1);
      check("bp_hold_data", 64'(out_data), 64'hDEADBEEF);
      check("bp_hold_sel", 64'(out_sel), 64'h0);
    end
    out_ready = 1'b1;
    expect_cycle("bp_reload", 4'b0010);
    check("bp_new_data", 64'(out_data), 64'h11111111);
    in_valid = '0;
    expect_cycle("bp_drain", 4'b0000);
    check("bp_empty", 64'(out_valid), 64'h0);
    check("bp_keep_data", 64'(out_data), 64'h11111111);

    // Fixed mode sel=2, then channel 2 goes idle, then round-robin from rr_ptr=3.
    do_reset();
    for (int i = 0; i < N; i++) chan_data[i] = $urandom;
    out_ready = 1'b1;
    mode      = 1'b1;
    sel       = 2'd2;
    in_valid  = 4'b1111;
    for (int k = 0; k < 3; k++) expect_cycle("fx_ch2", 4'b0100);
    in_valid = 4'b1011;
    expect_cycle("fx_none", 4'b0000);
    check("fx_fall", 64'(out_valid), 64'h0);
    mode     = 1'b0;
    in_valid = 4'b1111;
    expect_cycle("fx_rr_kept", 4'b0001);
    in_valid = '0;
    expect_cycle("fx_drain", 4'b0000);

    // Mode switch: rr_ptr=1, fixed sel=3 twice, then round-robin resumes at 2.
    do_reset();
    for (int i = 0; i < N; i++) chan_data[i] = $urandom;
    out_ready = 1'b1;
    in_valid  = 4'b0010;
    expect_cycle("ms_set", 4'b0010);
    mode     = 1'b1;
    sel      = 2'd3;
    in_valid = 4'b1111;
    expect_cycle("ms_fix1", 4'b1000);
    expect_cycle("ms_fix2", 4'b1000);
    mode = 1'b0;
    expect_cycle("ms_rr2", 4'b0100);
    expect_cycle("ms_rr3", 4'b1000);
    expect_cycle("ms_rr0", 4'b0001);
    in_valid = '0;
    expect_cycle("ms_drain", 4'b0000);
    expect_cycle("ms_drain", 4'b0000);

    // Asynchronous reset while a word is held in the output register.
    do_reset();
    chan_data[2] = 32'hCAFE0002;
    in_valid  = 4'b0100;
    expect_cycle("ar_load", 4'b0100);
    check("ar_held", 64'(out_valid), 64'h1);
    in_valid = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'h0);
    check("ar_data", 64'(out_data), 64'h0);
    check("ar_sel", 64'(out_sel), 64'h0);
    check("ar_ready", 64'(in_ready), 64'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    expect_cycle("ar_first", 4'b0001);
    in_valid = '0;
    expect_cycle("ar_drain", 4'b0000);
    expect_cycle("ar_drain", 4'b0000);

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
